// File: rtl/multicore_launch_ctrl.sv
// Launch sequencer for the multicore array: waits for enabled cores to be ready,
// pulses start once, collects done from each enabled core and times the run.
module multicore_launch_ctrl #(
  parameter int CORE_COUNT     = 4,
  parameter int CNT_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  launch,
  input  logic [CORE_COUNT-1:0] coreEn,
  input  logic [CORE_COUNT-1:0] coreReady,
  input  logic [CORE_COUNT-1:0] coreDone,
  output logic [CORE_COUNT-1:0] coreStart,
  output logic                  busy,
  output logic                  allDone,
  output logic                  timedOut,
  output logic [CORE_COUNT-1:0] doneMask,
  output logic [CNT_WIDTH-1:0]  cycleCount
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_READY,
    START,
    RUN,
    FINISH,
    TIMEOUT
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  // Only meaningful when TIMEOUT_CYCLES != 0; TO_EN guards its use.
  localparam logic [CNT_WIDTH-1:0] TO_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam bit                   TO_EN   = (TIMEOUT_CYCLES != 0);

  state_t                  state_q, state_d;
  logic [CORE_COUNT-1:0]   en_mask_q, en_mask_d;
  logic [CORE_COUNT-1:0]   core_start_q, core_start_d;
  logic                    busy_q, busy_d;
  logic                    all_done_q, all_done_d;
  logic                    timed_out_q, timed_out_d;
  logic [CORE_COUNT-1:0]   done_mask_q, done_mask_d;
  logic [CNT_WIDTH-1:0]    cycle_cnt_q, cycle_cnt_d;
  logic [CORE_COUNT-1:0]   done_next;
  logic                    launch_ok;

  always_comb begin
    state_d      = state_q;
    en_mask_d    = en_mask_q;
    core_start_d = '0;
    busy_d       = busy_q;
    all_done_d   = all_done_q;
    timed_out_d  = timed_out_q;
    done_mask_d  = done_mask_q;
    cycle_cnt_d  = cycle_cnt_q;
    done_next    = done_mask_q | (coreDone & en_mask_q);
    launch_ok    = launch && (coreEn != '0);

    case (state_q)
      IDLE, FINISH, TIMEOUT: begin
        if (launch_ok) begin
          en_mask_d   = coreEn;
          busy_d      = 1'b1;
          all_done_d  = 1'b0;
          timed_out_d = 1'b0;
          state_d     = WAIT_READY;
        end
      end
      WAIT_READY: begin
        // Start is registered, so it is raised on entry to START and lasts one cycle.
        if ((coreReady & en_mask_q) == en_mask_q) begin
          core_start_d = en_mask_q;
          state_d      = START;
        end
      end
      START: begin
        done_mask_d = '0;
        cycle_cnt_d = '0;
        state_d     = RUN;
      end
      RUN: begin
        done_mask_d = done_next;
        cycle_cnt_d = (cycle_cnt_q == CNT_MAX) ? cycle_cnt_q : cycle_cnt_q + CNT_ONE;
        // Completion is checked first so a last-cycle done beats the timeout.
        if (done_next == en_mask_q) begin
          busy_d     = 1'b0;
          all_done_d = 1'b1;
          state_d    = FINISH;
        end else if (TO_EN && (cycle_cnt_q == TO_LAST)) begin
          busy_d      = 1'b0;
          timed_out_d = 1'b1;
          state_d     = TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      en_mask_q    <= '0;
      core_start_q <= '0;
      busy_q       <= 1'b0;
      all_done_q   <= 1'b0;
      timed_out_q  <= 1'b0;
      done_mask_q  <= '0;
      cycle_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      en_mask_q    <= en_mask_d;
      core_start_q <= core_start_d;
      busy_q       <= busy_d;
      all_done_q   <= all_done_d;
      timed_out_q  <= timed_out_d;
      done_mask_q  <= done_mask_d;
      cycle_cnt_q  <= cycle_cnt_d;
    end
  end

  assign coreStart  = core_start_q;
  assign busy       = busy_q;
  assign allDone    = all_done_q;
  assign timedOut   = timed_out_q;
  assign doneMask   = done_mask_q;
  assign cycleCount = cycle_cnt_q;

endmodule

// File: tb/tb_multicore_launch_ctrl.sv
// Directed bench for multicore_launch_ctrl (4 cores, 32-bit counter, 50-cycle timeout).
module tb_multicore_launch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        launch;
  logic [3:0]  coreEn;
  logic [3:0]  coreReady;
  logic [3:0]  coreDone;
  logic [3:0]  coreStart;
  logic        busy;
  logic        allDone;
  logic        timedOut;
  logic [3:0]  doneMask;
  logic [31:0] cycleCount;

  int checks   = 0;
  int failures = 0;

  logic [2:0]  status;
  logic [42:0] all_out;
  assign status  = {busy, allDone, timedOut};
  assign all_out = {coreStart, busy, allDone, timedOut, doneMask, cycleCount};

  multicore_launch_ctrl #(
    .CORE_COUNT    (4),
    .CNT_WIDTH     (32),
    .TIMEOUT_CYCLES(50)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .launch    (launch),
    .coreEn    (coreEn),
    .coreReady (coreReady),
    .coreDone  (coreDone),
    .coreStart (coreStart),
    .busy      (busy),
    .allDone   (allDone),
    .timedOut  (timedOut),
    .doneMask  (doneMask),
    .cycleCount(cycleCount)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; launch = 1'b0; coreEn = 4'h0; coreReady = 4'h0; coreDone = 4'h0;
    repeat (3) step();
    checks++;
    if (all_out !== 43'd0) begin
      failures++; $display("FAIL reset_hold got=%h exp=0", all_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      checks++;
      if (all_out !== 43'd0) begin
        failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=0", i, all_out);
      end
    end
  endtask

  task automatic test_nominal();
    logic [3:0] pat;
    logic [3:0] exp_mask;
    coreEn = 4'hF; coreReady = 4'hF; launch = 1'b1;
    step(); launch = 1'b0;
    checks++;
    if (status !== 3'b100 || coreStart !== 4'h0) begin
      failures++; $display("FAIL nom_accept status=%b start=%h exp 100/0", status, coreStart);
    end
    step();
    checks++;
    if (coreStart !== 4'hF) begin
      failures++; $display("FAIL nom_start got=%h exp=f", coreStart);
    end
    step();
    checks++;
    if (coreStart !== 4'h0 || doneMask !== 4'h0 || cycleCount !== 32'd0) begin
      failures++; $display("FAIL nom_run_entry start=%h mask=%h cnt=%0d exp 0/0/0", coreStart, doneMask, cycleCount);
    end
    exp_mask = 4'h0;
    for (int k = 1; k <= 20; k++) begin
      pat = (k == 5) ? 4'b0001 : (k == 9) ? 4'b0010 : (k == 12) ? 4'b0100 : (k == 20) ? 4'b1000 : 4'b0000;
      coreDone = pat;
      step(); coreDone = 4'h0;
      exp_mask = exp_mask | pat;
      checks++;
      if (doneMask !== exp_mask || cycleCount !== k || coreStart !== 4'h0 ||
          status !== ((k == 20) ? 3'b010 : 3'b100)) begin
        failures++;
        $display("FAIL nom_run k=%0d mask=%h cnt=%0d start=%h status=%b exp mask=%h cnt=%0d",
                 k, doneMask, cycleCount, coreStart, status, exp_mask, k);
      end
    end
    repeat (2) step();
    checks++;
    if (status !== 3'b010 || doneMask !== 4'hF || cycleCount !== 32'd20 || coreStart !== 4'h0) begin
      failures++; $display("FAIL nom_finish_hold status=%b mask=%h cnt=%0d exp 010/f/20", status, doneMask, cycleCount);
    end
  endtask

  task automatic test_partial();
    launch = 1'b1; coreEn = 4'h0;
    step(); launch = 1'b0;
    checks++;
    if (status !== 3'b010 || doneMask !== 4'hF) begin
      failures++; $display("FAIL finish_zero_en status=%b mask=%h exp 010/f", status, doneMask);
    end
    launch = 1'b1; coreEn = 4'b0101; coreReady = 4'b0001;
    step(); launch = 1'b0; coreEn = 4'h0;
    checks++;
    if (status !== 3'b100) begin
      failures++; $display("FAIL part_accept status=%b exp=100", status);
    end
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (coreStart !== 4'h0) begin
        failures++; $display("FAIL part_ready_wait cyc=%0d start=%h exp=0", i, coreStart);
      end
    end
    coreReady = 4'b0101;
    step();
    checks++;
    if (coreStart !== 4'b0101 || doneMask !== 4'hF || cycleCount !== 32'd20) begin
      failures++; $display("FAIL part_start start=%h mask=%h cnt=%0d exp 5/f/20", coreStart, doneMask, cycleCount);
    end
    coreReady = 4'h0;
    step();
    checks++;
    if (coreStart !== 4'h0 || doneMask !== 4'h0 || cycleCount !== 32'd0) begin
      failures++; $display("FAIL part_run_entry start=%h mask=%h cnt=%0d exp 0/0/0", coreStart, doneMask, cycleCount);
    end
    coreDone = 4'b0010; step();
    checks++;
    if (doneMask !== 4'h0 || cycleCount !== 32'd1) begin
      failures++; $display("FAIL part_disabled_done mask=%h cnt=%0d exp 0/1", doneMask, cycleCount);
    end
    coreDone = 4'b0001; step();
    checks++;
    if (doneMask !== 4'b0001 || status !== 3'b100) begin
      failures++; $display("FAIL part_core0 mask=%h status=%b exp 1/100", doneMask, status);
    end
    coreDone = 4'b0110; step();
    checks++;
    if (doneMask !== 4'b0101 || status !== 3'b010 || cycleCount !== 32'd3) begin
      failures++; $display("FAIL part_finish mask=%h status=%b cnt=%0d exp 5/010/3", doneMask, status, cycleCount);
    end
    coreDone = 4'hF; step(); coreDone = 4'h0;
    checks++;
    if (doneMask !== 4'b0101 || coreStart !== 4'h0 || status !== 3'b010) begin
      failures++; $display("FAIL part_done_outside_run mask=%h start=%h status=%b exp 5/0/010", doneMask, coreStart, status);
    end
  endtask

  task automatic test_simultaneous();
    coreEn = 4'hF; coreReady = 4'hF; launch = 1'b1;
    step(); launch = 1'b0;
    step();
    checks++;
    if (coreStart !== 4'hF) begin
      failures++; $display("FAIL sim_start got=%h exp=f", coreStart);
    end
    step();
    for (int k = 1; k <= 7; k++) begin
      coreDone = (k == 7) ? 4'hF : 4'h0;
      step(); coreDone = 4'h0;
      if (k == 6) begin
        checks++;
        if (doneMask !== 4'h0 || status !== 3'b100) begin
          failures++; $display("FAIL sim_before mask=%h status=%b exp 0/100", doneMask, status);
        end
      end
      if (k == 7) begin
        checks++;
        if (doneMask !== 4'hF || status !== 3'b010 || cycleCount !== 32'd7) begin
          failures++; $display("FAIL sim_finish mask=%h status=%b cnt=%0d exp f/010/7", doneMask, status, cycleCount);
        end
      end
    end
  endtask

  task automatic test_timeout();
    coreEn = 4'hF; coreReady = 4'hF; launch = 1'b1;
    step(); launch = 1'b0;
    step(); step();
    for (int k = 1; k <= 50; k++) begin
      coreDone = (k == 3) ? 4'b0111 : 4'h0;
      step(); coreDone = 4'h0;
      if (k == 49) begin
        checks++;
        if (status !== 3'b100 || cycleCount !== 32'd49) begin
          failures++; $display("FAIL to_before status=%b cnt=%0d exp 100/49", status, cycleCount);
        end
      end
      if (k == 50) begin
        checks++;
        if (status !== 3'b001 || doneMask !== 4'b0111 || cycleCount !== 32'd50) begin
          failures++; $display("FAIL to_fire status=%b mask=%h cnt=%0d exp 001/7/50", status, doneMask, cycleCount);
        end
      end
    end
    step();
    checks++;
    if (status !== 3'b001 || cycleCount !== 32'd50 || coreStart !== 4'h0) begin
      failures++; $display("FAIL to_hold status=%b cnt=%0d start=%h exp 001/50/0", status, cycleCount, coreStart);
    end
    launch = 1'b1;
    step(); launch = 1'b0;
    checks++;
    if (status !== 3'b100) begin
      failures++; $display("FAIL to_relaunch status=%b exp=100", status);
    end
    step();
    checks++;
    if (coreStart !== 4'hF) begin
      failures++; $display("FAIL to_restart got=%h exp=f", coreStart);
    end
    step();
    for (int k = 1; k <= 50; k++) begin
      coreDone = (k == 1) ? 4'b0111 : (k == 50) ? 4'b1000 : 4'h0;
      step(); coreDone = 4'h0;
      if (k == 50) begin
        checks++;
        if (status !== 3'b010 || doneMask !== 4'hF || cycleCount !== 32'd50) begin
          failures++; $display("FAIL to_done_wins status=%b mask=%h cnt=%0d exp 010/f/50", status, doneMask, cycleCount);
        end
      end
    end
  endtask

  task automatic test_abort();
    coreEn = 4'hF; coreReady = 4'hF; launch = 1'b1;
    step(); step();
    checks++;
    if (coreStart !== 4'hF) begin
      failures++; $display("FAIL abort_start got=%h exp=f", coreStart);
    end
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (coreStart !== 4'h0 || status !== 3'b100) begin
        failures++; $display("FAIL abort_launch_in_run cyc=%0d start=%h status=%b exp 0/100", i, coreStart, status);
      end
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (all_out !== 43'd0) begin
      failures++; $display("FAIL abort_async_reset got=%h exp=0", all_out);
    end
    launch = 1'b0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (all_out !== 43'd0) begin
        failures++; $display("FAIL abort_release cyc=%0d got=%h exp=0", i, all_out);
      end
    end
    launch = 1'b1; coreEn = 4'h0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (all_out !== 43'd0) begin
        failures++; $display("FAIL idle_zero_en cyc=%0d got=%h exp=0", i, all_out);
      end
    end
    launch = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_partial();
    test_simultaneous();
    test_timeout();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
